// File: rtl/wb_merge.sv
// Write-back merge: pipeline writes win the register-file port, MDU results
// queue in a small FIFO and are squashed when a newer pipeline write hits the same register.
module wb_merge #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_wa,
    input  logic [31:0] mdu_wd,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic [31:0] busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DEPTH-1:0]       fifo_vld_q, fifo_vld_d;
    logic [DEPTH-1:0][4:0]  fifo_wa_q, fifo_wa_d;
    logic [DEPTH-1:0][31:0] fifo_wd_q, fifo_wd_d;
    logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   we_q, we_d;
    logic [4:0]             wa_q, wa_d;
    logic [31:0]            wd_q, wd_d;

    logic        pipe_act_s, fire_s, empty_s, drop_s, mdu_ok_s;
    logic        pop_s, direct_s, push_s;
    logic [31:0] busy_s;

    assign mdu_ready  = (count_q < DEPTH_C);
    assign pipe_act_s = pipe_we && (pipe_wa != 5'd0);
    assign fire_s     = mdu_valid && mdu_ready;
    assign empty_s    = (count_q == {CW{1'b0}});
    // A same-cycle pipe write to the same register is newer, so the MDU result is discarded.
    assign drop_s     = fire_s && pipe_act_s && (mdu_wa == pipe_wa);
    assign mdu_ok_s   = fire_s && (mdu_wa != 5'd0) && !drop_s;
    assign pop_s      = !pipe_act_s && !empty_s;
    assign direct_s   = !pipe_act_s && empty_s && mdu_ok_s;
    assign push_s     = mdu_ok_s && !direct_s;

    // Next-state for FIFO, pointers, count and the registered write port.
    always_comb begin
        fifo_wa_d = fifo_wa_q;
        fifo_wd_d = fifo_wd_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        we_d      = 1'b0;
        wa_d      = 5'd0;
        wd_d      = 32'd0;

        for (int i = 0; i < DEPTH; i++) begin
            fifo_vld_d[i] = fifo_vld_q[i] && !(pipe_act_s && (fifo_wa_q[i] == pipe_wa));
        end

        if (pipe_act_s) begin
            we_d = 1'b1;
            wa_d = pipe_wa;
            wd_d = pipe_wd;
        end else if (pop_s) begin
            we_d = fifo_vld_q[head_q];
            wa_d = fifo_vld_q[head_q] ? fifo_wa_q[head_q] : 5'd0;
            wd_d = fifo_vld_q[head_q] ? fifo_wd_q[head_q] : 32'd0;
        end else if (direct_s) begin
            we_d = 1'b1;
            wa_d = mdu_wa;
            wd_d = mdu_wd;
        end else begin
            we_d = 1'b0;
        end

        if (pop_s) begin
            fifo_vld_d[head_q] = 1'b0;
            head_d             = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end

        // Push never lands on the popped slot: pop needs count>0, push needs count<DEPTH.
        if (push_s) begin
            fifo_vld_d[tail_q] = 1'b1;
            fifo_wa_d[tail_q]  = mdu_wa;
            fifo_wd_d[tail_q]  = mdu_wd;
            tail_d             = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Busy vector from valid queued entries; x0 is never reported.
    always_comb begin
        busy_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_s[fifo_wa_q[i]] = busy_s[fifo_wa_q[i]] | fifo_vld_q[i];
        end
        busy_s[0] = 1'b0;
    end

    assign busy = busy_s;
    assign we   = we_q;
    assign wa   = wa_q;
    assign wd   = wd_q;

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_vld_q <= '0;
            fifo_wa_q  <= '0;
            fifo_wd_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            wa_q       <= 5'd0;
            wd_q       <= 32'd0;
        end else begin
            fifo_vld_q <= fifo_vld_d;
            fifo_wa_q  <= fifo_wa_d;
            fifo_wd_q  <= fifo_wd_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end
endmodule

// File: tb/tb_wb_merge.sv
// Scoreboard bench for wb_merge: stimulus pushes expected writes, a negedge
// monitor pops and compares every register-file write the DUT presents.
module tb_wb_merge;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_wa;
    logic [31:0] mdu_wd;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Low registers (x0..x15) and high registers (x16..x31) each deliver in order.
    logic [36:0] exp_lo[$];
    logic [36:0] exp_hi[$];
    logic [31:0] rf[32];

    wb_merge #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd),
        .we(we), .wa(wa), .wd(wd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        pipe_we = pw; pipe_wa = pa; pipe_wd = pd;
        mdu_valid = mv; mdu_wa = ma; mdu_wd = md;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: every presented write must match the head of its queue.
    always @(negedge clk) begin
        if (!rst && we) begin
            rf[wa] <= wd;
            if (wa >= 5'd16) begin
                if (exp_hi.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write: got x%0d=0x%0h expected none", wa, wd);
                end else begin
                    chk("wb_hi", {27'd0, wa, wd}, {27'd0, exp_hi.pop_front()});
                end
            end else begin
                if (exp_lo.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write: got x%0d=0x%0h expected none", wa, wd);
                end else begin
                    chk("wb_lo", {27'd0, wa, wd}, {27'd0, exp_lo.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, pn, burst, gap, guard;
        logic pw;
        rst = 1'b1;
        idle();
        #12;
        rst = 1'b0;
        chk("rst_we", we, 1'b0);
        chk("rst_wa", wa, 5'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ready", mdu_ready, 1'b1);

        // Priority and queueing
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd7, 32'hAB); exp_lo.push_back({5'd5, 32'h11}); cyc();
        chk("prio_busy7_c1", busy[7], 1'b1);
        chk("prio_ready_c1", mdu_ready, 1'b1);
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd8, 32'hCD); exp_lo.push_back({5'd5, 32'h11}); cyc();
        chk("prio_ready_c2", mdu_ready, 1'b0);
        chk("prio_busy78_c2", busy & 32'h180, 32'h180);
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0); exp_lo.push_back({5'd5, 32'h11}); cyc();
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0); exp_lo.push_back({5'd5, 32'h11}); cyc();
        chk("prio_ready_c4", mdu_ready, 1'b0);
        chk("prio_wa_c4", {we, wa}, {1'b1, 5'd5});
        idle();
        exp_lo.push_back({5'd7, 32'hAB});
        exp_lo.push_back({5'd8, 32'hCD});
        cyc();
        chk("prio_c5", {we, wa, wd}, {1'b1, 5'd7, 32'hAB});
        chk("prio_ready_c5", mdu_ready, 1'b1);
        cyc();
        chk("prio_c6", {we, wa, wd}, {1'b1, 5'd8, 32'hCD});
        chk("prio_busy_c6", busy, 32'd0);
        cyc();
        chk("prio_c7_we", we, 1'b0);

        // Direct path
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF); exp_lo.push_back({5'd3, 32'hDEADBEEF}); cyc();
        chk("direct_out", {we, wa, wd}, {1'b1, 5'd3, 32'hDEADBEEF});
        chk("direct_busy", busy, 32'd0);
        idle(); cyc();
        chk("direct_after", we, 1'b0);

        // Squash
        drive(1'b1, 5'd5, 32'h22, 1'b1, 5'd9, 32'h1); exp_lo.push_back({5'd5, 32'h22}); cyc();
        chk("squash_busy9_set", busy[9], 1'b1);
        drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0); exp_lo.push_back({5'd9, 32'h2}); cyc();
        chk("squash_busy9_clr", busy[9], 1'b0);
        chk("squash_pipe_x9", {we, wa, wd}, {1'b1, 5'd9, 32'h2});
        idle(); cyc();
        chk("squash_pop_we0", we, 1'b0);
        chk("squash_rf9", rf[9], 32'h2);
        cyc();
        chk("squash_idle_we0", we, 1'b0);

        // Same-cycle drop, x0 results, and count still zero afterwards
        drive(1'b1, 5'd4, 32'h6, 1'b1, 5'd4, 32'h5); exp_lo.push_back({5'd4, 32'h6}); cyc();
        chk("drop_busy", busy, 32'd0);
        chk("drop_wd", {we, wa, wd}, {1'b1, 5'd4, 32'h6});
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h7); cyc();
        chk("mdu_x0_we", we, 1'b0);
        drive(1'b1, 5'd0, 32'h9, 1'b0, 5'd0, 32'd0); cyc();
        chk("pipe_x0_we", we, 1'b0);
        chk("x0_busy", busy, 32'd0);
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA); exp_lo.push_back({5'd1, 32'h1}); cyc();
        chk("count_one_ready", mdu_ready, 1'b1);
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB); exp_lo.push_back({5'd1, 32'h1}); cyc();
        chk("count_two_ready", mdu_ready, 1'b0);
        exp_lo.push_back({5'd10, 32'hA});
        exp_lo.push_back({5'd11, 32'hB});
        idle(); cyc(); cyc(); cyc();
        chk("drain_we0", we, 1'b0);
        chk("drain_ready", mdu_ready, 1'b1);

        // Wrap-around with bursty pipe traffic
        sent = 0; pn = 0; burst = 0; gap = 0; guard = 0;
        while (sent < 10 && guard < 300) begin
            guard++;
            if (burst == 0 && gap == 0) begin
                burst = $urandom_range(0, 4);
                gap   = $urandom_range(0, 2);
            end
            pw = (burst > 0);
            if (burst > 0) burst--;
            else if (gap > 0) gap--;
            pipe_we = pw; pipe_wa = 5'd1; pipe_wd = 32'h100 + pn;
            if (pw) begin
                exp_lo.push_back({5'd1, 32'h100 + pn});
                pn++;
            end
            mdu_valid = 1'b1; mdu_wa = 5'd16 + sent[4:0]; mdu_wd = 32'h1000 + sent;
            if (mdu_ready) begin
                exp_hi.push_back({5'd16 + sent[4:0], 32'h1000 + sent});
                sent++;
            end
            cyc();
        end
        chk("wrap_all_sent", sent, 10);
        idle();
        repeat (8) cyc();
        chk("wrap_lo_drained", exp_lo.size(), 0);
        chk("wrap_hi_drained", exp_hi.size(), 0);
        chk("wrap_busy", busy, 32'd0);

        // Reset mid-stream with two entries queued
        drive(1'b1, 5'd5, 32'h33, 1'b1, 5'd12, 32'hC); exp_lo.push_back({5'd5, 32'h33}); cyc();
        drive(1'b1, 5'd5, 32'h33, 1'b1, 5'd13, 32'hD); exp_lo.push_back({5'd5, 32'h33}); cyc();
        idle();
        @(negedge clk); #1;
        chk("mid_busy_pre", busy & 32'h3000, 32'h3000);
        chk("mid_ready_pre", mdu_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", we, 1'b0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_ready", mdu_ready, 1'b1);
        #1;
        rst = 1'b0;
        cyc();
        chk("mid_after1_we", we, 1'b0);
        cyc();
        chk("mid_after2_we", we, 1'b0);
        cyc();
        chk("mid_after3_we", we, 1'b0);
        chk("final_lo_empty", exp_lo.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
